// File: rtl/lsu_mem_access_pkg.sv
// rtl/lsu_mem_access_pkg.sv - shared state encoding, load-type indices and access size helpers
package lsu_mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam int LC_LD  = 0;
    localparam int LC_LW  = 1;
    localparam int LC_LWU = 2;
    localparam int LC_LH  = 3;
    localparam int LC_LHU = 4;
    localparam int LC_LB  = 5;
    localparam int LC_LBU = 6;

    localparam logic [7:0] WM_B = 8'h01;
    localparam logic [7:0] WM_H = 8'h03;
    localparam logic [7:0] WM_W = 8'h0F;
    localparam logic [7:0] WM_D = 8'hFF;

    // Irregular masks fall back to the span up to their highest set lane.
    function automatic logic [3:0] store_size(input logic [7:0] wmask);
        logic [3:0] sz;
        sz = 4'd0;
        case (wmask)
            WM_B:    sz = 4'd1;
            WM_H:    sz = 4'd2;
            WM_W:    sz = 4'd4;
            WM_D:    sz = 4'd8;
            default: begin
                for (int i = 0; i < 8; i++) begin
                    if (wmask[i]) sz = 4'(i + 1);
                end
            end
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] load_size(input logic [6:0] l_choose);
        logic [3:0] sz;
        if (l_choose[LC_LD])                          sz = 4'd8;
        else if (l_choose[LC_LW] || l_choose[LC_LWU]) sz = 4'd4;
        else if (l_choose[LC_LH] || l_choose[LC_LHU]) sz = 4'd2;
        else                                          sz = 4'd1;
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - right-align a 64-bit read word and sign/zero-extend by load type
module lsu_load_extend
    import lsu_mem_access_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [6:0]  l_choose,
    output logic [63:0] ext
);

    logic [63:0] shifted;

    // Lowest set l_choose bit wins; none set returns the shifted word zero-filled.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        ext     = shifted;
        if (l_choose[LC_LD])       ext = shifted;
        else if (l_choose[LC_LW])  ext = {{32{shifted[31]}}, shifted[31:0]};
        else if (l_choose[LC_LWU]) ext = {32'd0, shifted[31:0]};
        else if (l_choose[LC_LH])  ext = {{48{shifted[15]}}, shifted[15:0]};
        else if (l_choose[LC_LHU]) ext = {48'd0, shifted[15:0]};
        else if (l_choose[LC_LB])  ext = {{56{shifted[7]}}, shifted[7:0]};
        else if (l_choose[LC_LBU]) ext = {56'd0, shifted[7:0]};
    end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - load/store unit issuing one aligned 64-bit bus transaction per access
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_ram_en,
    input  logic          data_ram_wen,
    input  logic [7:0]    wmask,
    input  logic [6:0]    l_choose,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          req_valid,
    input  logic          req_ready,
    output logic          req_wen,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_wdata,
    output logic [7:0]    req_wstrb,
    input  logic          resp_valid,
    output logic          resp_ready,
    input  logic [DW-1:0] resp_rdata,
    output logic [DW-1:0] rdata,
    output logic          mem_finish,
    output logic          stall,
    output logic          misalign
);

    lsu_state_t    state;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [7:0]    cap_wmask;
    logic [6:0]    cap_lc;
    logic          cap_wen;

    logic          access;
    logic [3:0]    size;
    logic          misaligned_in;
    logic [63:0]   ext;

    assign access        = data_ram_en | data_ram_wen;
    assign size          = data_ram_wen ? store_size(wmask) : load_size(l_choose);
    assign misaligned_in = ({1'b0, addr[2:0]} + size) > 4'd8;

    // Idle with no access retires in the same cycle; any access holds the pipe until DONE.
    assign mem_finish = ((state == ST_IDLE) && !access) || (state == ST_DONE);
    assign stall      = ((state == ST_IDLE) && access) || (state == ST_REQ) || (state == ST_RESP);

    assign req_wen   = cap_wen;
    assign req_addr  = {cap_addr[AW-1:3], 3'b000};
    assign req_wdata = cap_wdata << {cap_addr[2:0], 3'b000};
    assign req_wstrb = cap_wen ? (cap_wmask << cap_addr[2:0]) : 8'h00;

    lsu_load_extend u_load_extend (
        .rdata    (resp_rdata),
        .offset   (cap_addr[2:0]),
        .l_choose (cap_lc),
        .ext      (ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_valid  <= 1'b0;
            resp_ready <= 1'b0;
            misalign   <= 1'b0;
            rdata      <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wmask  <= '0;
            cap_lc     <= '0;
            cap_wen    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_wmask <= wmask;
                        cap_lc    <= l_choose;
                        cap_wen   <= data_ram_wen;
                        if (misaligned_in) begin
                            state    <= ST_DONE;
                            misalign <= 1'b1;
                            rdata    <= '0;
                        end else begin
                            state     <= ST_REQ;
                            req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state      <= ST_RESP;
                        req_valid  <= 1'b0;
                        resp_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_valid) begin
                        state      <= ST_DONE;
                        resp_ready <= 1'b0;
                        rdata      <= cap_wen ? '0 : ext;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    misalign <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - self-checking bench for lsu_mem_access with a behavioural load/store model
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ram_en = 1'b0;
    logic        data_ram_wen = 1'b0;
    logic [7:0]  wmask = 8'h00;
    logic [6:0]  l_choose = 7'h00;
    logic [63:0] addr = 64'h0;
    logic [63:0] wdata = 64'h0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [63:0] resp_rdata = 64'h0;
    logic [63:0] rdata;
    logic        mem_finish;
    logic        stall;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    int          o_lat;
    int          o_nreq;
    logic        o_stable;
    logic        o_stall_ok;
    logic        o_mis;
    logic [63:0] o_rdata;
    logic [63:0] o_addr;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wen;

    always #5 clk = ~clk;

    lsu_mem_access #(.AW(64), .DW(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_ram_en  (data_ram_en),
        .data_ram_wen (data_ram_wen),
        .wmask        (wmask),
        .l_choose     (l_choose),
        .addr         (addr),
        .wdata        (wdata),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .rdata        (rdata),
        .mem_finish   (mem_finish),
        .stall        (stall),
        .misalign     (misalign)
    );

    always @(posedge clk) begin
        if (data_ram_en && data_ram_wen) $error("illegal: load and store requested together");
    end

    function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] off, input logic [6:0] lc);
        logic [63:0] v;
        logic [63:0] m;
        int          width;
        logic        sgn;
        v = rd >> (8 * off);
        if (lc[0] || lc == 7'd0) return v;
        if (lc[1])      begin width = 32; sgn = 1'b1; end
        else if (lc[2]) begin width = 32; sgn = 1'b0; end
        else if (lc[3]) begin width = 16; sgn = 1'b1; end
        else if (lc[4]) begin width = 16; sgn = 1'b0; end
        else if (lc[5]) begin width = 8;  sgn = 1'b1; end
        else            begin width = 8;  sgn = 1'b0; end
        m = (64'd1 << width) - 64'd1;
        v = v & m;
        if (sgn && v[width-1]) v = v | ~m;
        return v;
    endfunction

    function automatic int ref_size(input logic wen, input logic [7:0] wm, input logic [6:0] lc);
        if (wen) return $countones(wm);
        if (lc[0]) return 8;
        if (lc[1] || lc[2]) return 4;
        if (lc[3] || lc[4]) return 2;
        return 1;
    endfunction

    task automatic run_access(input logic en, input logic wen, input logic [63:0] a, input logic [63:0] wd,
                              input logic [7:0] wm, input logic [6:0] lc, input int rw, input int sw,
                              input logic [63:0] rd);
        int   nreq;
        int   nresp;
        logic first;
        @(negedge clk);
        data_ram_en = en; data_ram_wen = wen; addr = a; wdata = wd; wmask = wm; l_choose = lc;
        resp_rdata = rd; req_ready = 1'b0; resp_valid = 1'b0;
        o_lat = -1; o_nreq = 0; o_stable = 1'b1; o_stall_ok = 1'b1; o_mis = 1'bx; o_rdata = 'x;
        o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_wen = 1'bx;
        #1;
        if (mem_finish !== 1'b0 || stall !== 1'b1) o_stall_ok = 1'b0;
        nreq = 0; nresp = 0; first = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req_ready = 1'b0; resp_valid = 1'b0;
            #1;
            if (mem_finish === 1'b1) begin
                o_lat = c; o_rdata = rdata; o_mis = misalign;
                if (stall !== 1'b0) o_stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) o_stall_ok = 1'b0;
            if (req_valid === 1'b1) begin
                if (first) begin
                    o_addr = req_addr; o_wdata = req_wdata; o_wstrb = req_wstrb; o_wen = req_wen;
                    first = 1'b0;
                end else if (req_addr !== o_addr || req_wdata !== o_wdata || req_wstrb !== o_wstrb || req_wen !== o_wen) begin
                    o_stable = 1'b0;
                end
                req_ready = (nreq >= rw);
                nreq++;
            end
            if (resp_ready === 1'b1) begin
                resp_valid = (nresp >= sw);
                nresp++;
            end
        end
        o_nreq = nreq;
        @(posedge clk);
        #1;
        data_ram_en = 1'b0; data_ram_wen = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        checks++; if (resp_ready !== 1'b0) begin failures++; $display("FAIL reset_resp_ready got=%b exp=0", resp_ready); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        checks++; if (rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (mem_finish !== 1'b1) begin failures++; $display("FAIL reset_mem_finish got=%b exp=1", mem_finish); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_non_mem;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
            wmask = 8'($urandom); l_choose = 7'($urandom);
            #1;
            checks++; if (mem_finish !== 1'b1 || stall !== 1'b0 || req_valid !== 1'b0) begin
                failures++;
                $display("FAIL non_mem finish/stall/req got=%b%b%b exp=100", mem_finish, stall, req_valid);
            end
        end
    endtask

    task automatic test_lb_lbu;
        run_access(1'b1, 1'b0, 64'h8000_0003, 64'h0, 8'h00, 7'b0100000, 0, 0, 64'h0000_0000_80FF_0000);
        checks++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffffffffffff80", o_rdata); end
        checks++; if (o_lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", o_lat); end
        run_access(1'b1, 1'b0, 64'h8000_0003, 64'h0, 8'h00, 7'b1000000, 0, 0, 64'h0000_0000_80FF_0000);
        checks++; if (o_rdata !== 64'h80) begin failures++; $display("FAIL lbu_rdata got=%h exp=80", o_rdata); end
        checks++; if (o_lat !== 3) begin failures++; $display("FAIL lbu_latency got=%0d exp=3", o_lat); end
    endtask

    task automatic test_store_sh;
        run_access(1'b0, 1'b1, 64'h8000_0006, 64'h1234, 8'h03, 7'h00, 0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
        checks++; if (o_addr !== 64'h8000_0000) begin failures++; $display("FAIL sh_req_addr got=%h exp=80000000", o_addr); end
        checks++; if (o_wstrb !== 8'hC0) begin failures++; $display("FAIL sh_req_wstrb got=%h exp=c0", o_wstrb); end
        checks++; if (o_wdata !== 64'h1234_0000_0000_0000) begin failures++; $display("FAIL sh_req_wdata got=%h exp=1234000000000000", o_wdata); end
        checks++; if (o_wen !== 1'b1) begin failures++; $display("FAIL sh_req_wen got=%b exp=1", o_wen); end
        checks++; if (o_rdata !== 64'h0) begin failures++; $display("FAIL sh_rdata got=%h exp=0", o_rdata); end
    endtask

    task automatic test_backpressure;
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        run_access(1'b1, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 7'b0000001, 4, 2, rd);
        checks++; if (o_lat !== 9) begin failures++; $display("FAIL bp_latency got=%0d exp=9", o_lat); end
        checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL bp_req_stable got=%b exp=1", o_stable); end
        checks++; if (o_stall_ok !== 1'b1) begin failures++; $display("FAIL bp_stall got=%b exp=1", o_stall_ok); end
        checks++; if (o_nreq !== 5) begin failures++; $display("FAIL bp_req_cycles got=%0d exp=5", o_nreq); end
        checks++; if (o_rdata !== rd) begin failures++; $display("FAIL bp_rdata got=%h exp=%h", o_rdata, rd); end
    endtask

    task automatic test_misalign;
        run_access(1'b1, 1'b0, 64'h8000_0006, 64'h0, 8'h00, 7'b0000010, 0, 0, 64'h1111_2222_3333_4444);
        checks++; if (o_nreq !== 0) begin failures++; $display("FAIL mis_req_cycles got=%0d exp=0", o_nreq); end
        checks++; if (o_mis !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", o_mis); end
        checks++; if (o_lat !== 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", o_lat); end
        checks++; if (o_rdata !== 64'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", o_rdata); end
        @(negedge clk);
        #1;
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
    endtask

    task automatic test_lchoose_zero;
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        run_access(1'b1, 1'b0, 64'h8000_0020, 64'h0, 8'h00, 7'h00, 0, 0, rd);
        checks++; if (o_rdata !== rd) begin failures++; $display("FAIL lc0_rdata got=%h exp=%h", o_rdata, rd); end
    endtask

    task automatic test_reset_mid;
        logic        hit;
        logic [63:0] rd;
        hit = 1'b0;
        @(negedge clk);
        data_ram_en = 1'b1; l_choose = 7'b0000001; addr = 64'h8000_0040;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (resp_ready === 1'b1) begin hit = 1'b1; req_ready = 1'b0; break; end
            req_ready = req_valid;
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rstmid_reach_resp got=%b exp=1", hit); end
        rst_n = 1'b0; data_ram_en = 1'b0; req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle req/resp got=%b%b exp=00", req_valid, resp_ready);
        end
        checks++; if (mem_finish !== 1'b1) begin failures++; $display("FAIL rstmid_finish got=%b exp=1", mem_finish); end
        resp_valid = 1'b1; resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rdata !== 64'h0 || req_valid !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_late_resp rdata=%h req=%b stall=%b exp=0/0/0", rdata, req_valid, stall);
        end
        resp_valid = 1'b0;
        rd = {$urandom, $urandom};
        run_access(1'b1, 1'b0, 64'h8000_0048, 64'h0, 8'h00, 7'b0000001, 0, 0, rd);
        checks++; if (o_rdata !== rd || o_lat !== 3) begin
            failures++; $display("FAIL rstmid_next_ld rdata=%h lat=%0d exp=%h/3", o_rdata, o_lat, rd);
        end
    endtask

    task automatic test_random;
        logic        st;
        logic [2:0]  off;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [7:0]  wm;
        logic [6:0]  lc;
        logic [7:0]  masks [4];
        int          rw, sw, exp_lat;
        logic        mis;
        logic [63:0] exp_rd;
        masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;
        for (int i = 0; i < 60; i++) begin
            st  = 1'($urandom_range(0, 1));
            off = 3'($urandom_range(0, 7));
            a   = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 8 + 64'(off);
            wd  = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            wm  = masks[$urandom_range(0, 3)];
            lc  = 7'(1 << $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) lc = lc | 7'($urandom);
            rw  = $urandom_range(0, 3);
            sw  = $urandom_range(0, 3);
            mis = (int'(off) + ref_size(st, wm, lc)) > 8;
            exp_lat = mis ? 1 : 3 + rw + sw;
            exp_rd  = (mis || st) ? 64'h0 : ref_load(rd, off, lc);
            run_access(!st, st, a, wd, wm, lc, rw, sw, rd);
            checks++; if (o_lat !== exp_lat) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, o_lat, exp_lat); end
            checks++; if (o_rdata !== exp_rd) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, o_rdata, exp_rd); end
            checks++; if (o_mis !== mis || o_nreq !== (mis ? 0 : rw + 1)) begin
                failures++; $display("FAIL rnd%0d_misalign got=%b/%0d exp=%b/%0d", i, o_mis, o_nreq, mis, mis ? 0 : rw + 1);
            end
            if (!mis) begin
                checks++; if (o_addr !== {a[63:3], 3'b000} || o_wen !== st || o_stable !== 1'b1) begin
                    failures++; $display("FAIL rnd%0d_req addr=%h wen=%b stable=%b", i, o_addr, o_wen, o_stable);
                end
                if (st) begin
                    checks++; if (o_wstrb !== 8'((16'(wm) << off) & 16'hFF) || o_wdata !== (wd << (8 * off))) begin
                        failures++; $display("FAIL rnd%0d_store wstrb=%h wdata=%h", i, o_wstrb, o_wdata);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_lb_lbu();
        test_store_sh();
        test_backpressure();
        test_misalign();
        test_lchoose_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
